// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO on inferred RAM: programmable prog_full/prog_empty, flush, NORMAL or FWFT read port.
// Latency: flags and data_count update on the edge after an access; NORMAL dout 1 cycle after rd_en; FWFT head 1 cycle after write.
// Backpressure: writes while full and reads while empty are dropped and reported one cycle later by overflow/underflow.
module fifo_sync_prog #(
   parameter int               DSIZE             = 8,
   parameter int               ASIZE             = 4,
   parameter string            MODE              = "NORMAL",
   parameter int               PROG_FULL_THRESH  = 2**(ASIZE-1),
   parameter int               PROG_EMPTY_THRESH = 2**(ASIZE-1),
   parameter logic [DSIZE-1:0] DOUT_RESET        = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [DSIZE-1:0] din,
   input  logic             wr_en,
   output logic             full,
   output logic             prog_full,
   output logic             overflow,
   input  logic             rd_en,
   output logic [DSIZE-1:0] dout,
   output logic             empty,
   output logic             prog_empty,
   output logic             underflow,
   output logic [ASIZE:0]   data_count
);

   localparam int              DEPTH   = 2**ASIZE;
   localparam int              CW      = ASIZE + 1;
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0]   PF_C    = CW'(PROG_FULL_THRESH);
   localparam logic [CW-1:0]   PE_C    = CW'(PROG_EMPTY_THRESH);
   localparam logic [CW-1:0]   CNT_ONE = CW'(1);
   localparam logic [ASIZE-1:0] PTR_ONE = ASIZE'(1);
   localparam bit              IS_FWFT = (MODE == "FWFT");

   // Parameter legality is checked at elaboration so a bad instance never builds.
   if (MODE != "NORMAL" && MODE != "FWFT") begin : g_bad_mode
      $error("fifo_sync_prog: MODE must be \"NORMAL\" or \"FWFT\"");
   end
   if (DSIZE < 1 || ASIZE < 1) begin : g_bad_size
      $error("fifo_sync_prog: DSIZE and ASIZE must be at least 1");
   end
   if (PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > DEPTH) begin : g_bad_pf
      $error("fifo_sync_prog: PROG_FULL_THRESH must be in 1..DEPTH");
   end
   if (PROG_EMPTY_THRESH < 0 || PROG_EMPTY_THRESH > DEPTH-1) begin : g_bad_pe
      $error("fifo_sync_prog: PROG_EMPTY_THRESH must be in 0..DEPTH-1");
   end

   logic [DSIZE-1:0] mem [DEPTH];
   logic [ASIZE-1:0] wr_ptr;
   logic [ASIZE-1:0] rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;
   logic             wr_acc;
   logic             rd_acc;

   // Accept decisions use this cycle's registered flags; flush wins over both requests.
   assign wr_acc = wr_en & ~full  & ~flush;
   assign rd_acc = rd_en & ~empty & ~flush;

   // Occupancy after this edge; a simultaneous accepted read and write cancel out.
   always_comb begin
      count_next = count;
      if (wr_acc && !rd_acc) begin
         count_next = count + CNT_ONE;
      end else if (rd_acc && !wr_acc) begin
         count_next = count - CNT_ONE;
      end
   end

   // Read/write pointers; they wrap DEPTH-1 -> 0 through natural overflow of ASIZE bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // The count register is the only occupancy source; every level flag is registered from count_next.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count      <= '0;
         full       <= 1'b0;
         empty      <= 1'b1;
         prog_full  <= 1'b0;
         prog_empty <= 1'b1;
      end else if (flush) begin
         count      <= '0;
         full       <= 1'b0;
         empty      <= 1'b1;
         prog_full  <= 1'b0;
         prog_empty <= 1'b1;
      end else begin
         count      <= count_next;
         full       <= (count_next == DEPTH_C);
         empty      <= (count_next == '0);
         prog_full  <= (count_next >= PF_C);
         prog_empty <= (count_next <= PE_C);
      end
   end

   // Rejected-access pulses: one cycle, raised regardless of what the other port did.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= wr_en & full;
         underflow <= rd_en & empty;
      end
   end

   assign data_count = count;

   // Storage array; left unreset so it maps onto plain RAM. Stale words are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= din;
      end
   end

   if (IS_FWFT) begin : g_fwft
      // Head word is presented combinationally; meaningless but stable while empty.
      assign dout = mem[rd_ptr];
   end else begin : g_normal
      logic [DSIZE-1:0] dout_q;

      // Registered read port: loads on an accepted read, otherwise holds the last word.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dout_q <= DOUT_RESET;
         end else if (flush) begin
            dout_q <= DOUT_RESET;
         end else if (rd_acc) begin
            dout_q <= mem[rd_ptr];
         end
      end

      assign dout = dout_q;
   end

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Bench for fifo_sync_prog: NORMAL and FWFT instances driven by the same stimulus.
// A queue-based reference model predicts each cycle's outputs into a scoreboard;
// a monitor pops one prediction per clock and compares it with both instances.
module tb_fifo_sync_prog;

   localparam int         DW    = 8;
   localparam int         AW    = 4;
   localparam int         DEPTH = 16;
   localparam int         TH    = 8;
   localparam logic [7:0] DR    = 8'h5A;

   logic         clk   = 1'b0;
   logic         rst   = 1'b0;
   logic         flush = 1'b0;
   logic         wr_en = 1'b0;
   logic         rd_en = 1'b0;
   logic [DW-1:0] din  = '0;

   logic          n_full, n_pf, n_ov, n_empty, n_pe, n_un;
   logic [DW-1:0] n_dout;
   logic [AW:0]   n_cnt;
   logic          f_full, f_pf, f_ov, f_empty, f_pe, f_un;
   logic [DW-1:0] f_dout;
   logic [AW:0]   f_cnt;

   always #5 clk = ~clk;

   fifo_sync_prog #(
      .DSIZE(DW), .ASIZE(AW), .MODE("NORMAL"),
      .PROG_FULL_THRESH(TH), .PROG_EMPTY_THRESH(TH), .DOUT_RESET(DR)
   ) u_nrm (
      .clk(clk), .rst(rst), .flush(flush), .din(din), .wr_en(wr_en),
      .full(n_full), .prog_full(n_pf), .overflow(n_ov), .rd_en(rd_en),
      .dout(n_dout), .empty(n_empty), .prog_empty(n_pe), .underflow(n_un),
      .data_count(n_cnt)
   );

   fifo_sync_prog #(
      .DSIZE(DW), .ASIZE(AW), .MODE("FWFT"),
      .PROG_FULL_THRESH(TH), .PROG_EMPTY_THRESH(TH), .DOUT_RESET(DR)
   ) u_fw (
      .clk(clk), .rst(rst), .flush(flush), .din(din), .wr_en(wr_en),
      .full(f_full), .prog_full(f_pf), .overflow(f_ov), .rd_en(rd_en),
      .dout(f_dout), .empty(f_empty), .prog_empty(f_pe), .underflow(f_un),
      .data_count(f_cnt)
   );

   typedef struct {
      int         cnt;
      bit         ov;
      bit         un;
      logic [7:0] dn;
      logic [7:0] fd;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [7:0] q[$];
   logic [7:0] m_dout = DR;
   bit         m_ov   = 1'b0;
   bit         m_un   = 1'b0;
   int         n_tests = 0;
   int         n_fail  = 0;

   task automatic chk(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic chk_flags(input string tag, input int cnt, input logic full_a,
                            input logic empty_a, input logic pf_a, input logic pe_a,
                            input logic ov_a, input logic un_a, input logic [AW:0] cnt_a,
                            input bit ov_e, input bit un_e);
      chk({tag, "_count"},      int'(cnt_a),   cnt);
      chk({tag, "_full"},       int'(full_a),  int'(cnt == DEPTH));
      chk({tag, "_empty"},      int'(empty_a), int'(cnt == 0));
      chk({tag, "_prog_full"},  int'(pf_a),    int'(cnt >= TH));
      chk({tag, "_prog_empty"}, int'(pe_a),    int'(cnt <= TH));
      chk({tag, "_overflow"},   int'(ov_a),    int'(ov_e));
      chk({tag, "_underflow"},  int'(un_a),    int'(un_e));
   endtask

   // Monitor: one prediction per clock edge, compared 1 ns after the edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk_flags("nrm", mon_e.cnt, n_full, n_empty, n_pf, n_pe, n_ov, n_un, n_cnt, mon_e.ov, mon_e.un);
         chk_flags("fw",  mon_e.cnt, f_full, f_empty, f_pf, f_pe, f_ov, f_un, f_cnt, mon_e.ov, mon_e.un);
         chk("nrm_dout", int'(n_dout), int'(mon_e.dn));
         if (mon_e.cnt > 0) begin
            chk("fw_head", int'(f_dout), int'(mon_e.fd));
         end
      end
   end

   // Drive one cycle of stimulus and push the model's prediction for the following edge.
   task automatic cycle(input bit wr, input bit rd, input logic [7:0] d, input bit fl);
      exp_t e;
      int   c;
      @(negedge clk);
      wr_en = wr;
      rd_en = rd;
      din   = d;
      flush = fl;
      if (fl) begin
         q.delete();
         m_dout = DR;
         m_ov   = 1'b0;
         m_un   = 1'b0;
      end else begin
         c    = q.size();
         m_ov = wr && (c == DEPTH);
         m_un = rd && (c == 0);
         if (rd && c > 0) m_dout = q.pop_front();
         if (wr && c < DEPTH) q.push_back(d);
      end
      e.cnt = q.size();
      e.ov  = m_ov;
      e.un  = m_un;
      e.dn  = m_dout;
      e.fd  = (q.size() > 0) ? q[0] : 8'h00;
      exp_q.push_back(e);
   endtask

   task automatic chk_reset(input string tag);
      chk_flags({tag, "_nrm"}, 0, n_full, n_empty, n_pf, n_pe, n_ov, n_un, n_cnt, 1'b0, 1'b0);
      chk_flags({tag, "_fw"},  0, f_full, f_empty, f_pf, f_pe, f_ov, f_un, f_cnt, 1'b0, 1'b0);
      chk({tag, "_nrm_dout"}, int'(n_dout), int'(DR));
   endtask

   // Assert reset between clock edges while a write is being requested.
   task automatic async_reset();
      @(negedge clk);
      wr_en = 1'b1;
      rd_en = 1'b0;
      flush = 1'b0;
      din   = 8'hCC;
      #2 rst = 1'b1;
      #1 chk_reset("arst");
      q.delete();
      m_dout = DR;
      m_ov   = 1'b0;
      m_un   = 1'b0;
      wr_en  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   int pw;
   int pr;

   initial begin
      #1 rst = 1'b1;
      #2 chk_reset("por");
      @(negedge clk);
      rst = 1'b0;

      // Fill 0x00..0x0F, then one write into a full FIFO.
      for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, (i < 16) ? 8'(i) : 8'hEE, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0);

      // Drain all 16 plus one read from empty.
      for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0);

      // Single word through an empty FIFO.
      cycle(1'b1, 1'b0, 8'hA5, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0);

      // Steady state at count 5 with simultaneous traffic; pointers wrap.
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
      for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 8'($urandom), 1'b0);

      // Both requests while full, then while empty.
      while (q.size() < DEPTH) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
      cycle(1'b1, 1'b1, 8'h99, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      while (q.size() > 0) cycle(1'b0, 1'b1, 8'h00, 1'b0);
      cycle(1'b1, 1'b1, 8'h77, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0);

      // Flush at count 9 while requesting a write and a read.
      while (q.size() < 9) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
      cycle(1'b1, 1'b1, 8'h11, 1'b1);
      cycle(1'b0, 1'b0, 8'h00, 1'b0);

      // Random traffic with alternating fill/drain bias and rare flushes.
      for (int i = 0; i < 3000; i++) begin
         pw = ((i / 300) % 2 == 0) ? 70 : 30;
         pr = 100 - pw;
         cycle($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
               8'($urandom), $urandom_range(0, 199) == 0);
      end

      // Reset in the middle of a write burst, then resume.
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
      async_reset();
      for (int i = 0; i < 200; i++) begin
         cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom), 1'b0);
      end
      cycle(1'b0, 1'b0, 8'h00, 1'b0);

      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
